// File: rtl/comparator_sequencer.sv
// Timing controller for a dynamic comparator: precharge/evaluate sequencing,
// 2-flop synchronised sampling and majority voting over VOTES decisions.
module comparator_sequencer #(
    parameter int SETTLE_CYC = 2,
    parameter int EVAL_CYC   = 3,
    parameter int VOTES      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       cmp_out,
    output logic       cmp_rst,
    output logic       cmp_en,
    output logic       busy,
    output logic       result,
    output logic [3:0] ones_cnt,
    output logic       unstable,
    output logic       result_valid
);

    typedef enum logic [1:0] {IDLE, RESET, EVAL, DONE} state_t;

    state_t     state;
    logic       sync1, sync2, sync_prev;
    logic [3:0] phase_cnt;
    logic [3:0] vote_cnt;
    logic [3:0] ones_acc;
    logic       unstable_acc;

    logic       last_eval;
    logic       last_vote;
    logic [3:0] ones_next;
    logic       unstable_next;

    // sync_prev holds sync2 from the previous cycle for the stability check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= cmp_out;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign last_eval     = (state == EVAL) && (phase_cnt == 4'(EVAL_CYC - 1));
    assign last_vote     = ((5'(vote_cnt) + 5'd1) >= 5'(VOTES));
    assign ones_next     = ones_acc + {3'b000, sync2};
    assign unstable_next = unstable_acc | (sync2 != sync_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmp_rst      <= 1'b1;
            cmp_en       <= 1'b0;
            busy         <= 1'b0;
            result       <= 1'b0;
            ones_cnt     <= 4'd0;
            unstable     <= 1'b0;
            result_valid <= 1'b0;
            phase_cnt    <= 4'd0;
            vote_cnt     <= 4'd0;
            ones_acc     <= 4'd0;
            unstable_acc <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (abort && state != IDLE) begin
                // Abandon without touching the published result
                state     <= IDLE;
                cmp_rst   <= 1'b1;
                cmp_en    <= 1'b0;
                busy      <= 1'b0;
                phase_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state        <= RESET;
                            busy         <= 1'b1;
                            phase_cnt    <= 4'd0;
                            vote_cnt     <= 4'd0;
                            ones_acc     <= 4'd0;
                            unstable_acc <= 1'b0;
                        end
                    end
                    RESET: begin
                        if (phase_cnt == 4'(SETTLE_CYC - 1)) begin
                            state     <= EVAL;
                            cmp_rst   <= 1'b0;
                            cmp_en    <= 1'b1;
                            phase_cnt <= 4'd0;
                        end else begin
                            phase_cnt <= phase_cnt + 4'd1;
                        end
                    end
                    EVAL: begin
                        if (last_eval) begin
                            ones_acc     <= ones_next;
                            unstable_acc <= unstable_next;
                            vote_cnt     <= vote_cnt + 4'd1;
                            phase_cnt    <= 4'd0;
                            cmp_en       <= 1'b0;
                            cmp_rst      <= 1'b1;
                            if (last_vote) begin
                                state        <= DONE;
                                ones_cnt     <= ones_next;
                                result       <= (ones_next > 4'(VOTES / 2));
                                unstable     <= unstable_next;
                                result_valid <= 1'b1;
                            end else begin
                                state <= RESET;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 4'd1;
                        end
                    end
                    DONE: begin
                        if (cont) begin
                            state        <= RESET;
                            phase_cnt    <= 4'd0;
                            vote_cnt     <= 4'd0;
                            ones_acc     <= 4'd0;
                            unstable_acc <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cmp_rst <= 1'b1;
                        cmp_en  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
